// File: rtl/slave_fifo_scheduler_pkg.sv
// Shared encodings and default sizing for the slave FIFO read-side scheduler.
package slave_fifo_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_READ = 3'd2,
        S_STOP = 3'd3
    } state_t;

    localparam int DATA_W_DEF    = 32;
    localparam int BURST_LEN_DEF = 16;
    localparam int CNT_W_DEF     = 5;

endpackage

// File: rtl/slave_fifo_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the source preferred next
// and moves past the finished source on a done pulse.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic [1:0] done_gnt,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (ptr) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= (done_gnt == 2'b01);
        end
    end

endmodule

// File: rtl/slave_fifo_scheduler.sv
// Read-side scheduler for the CPLD-as-FIFO slave: round-robin burst grants
// between two sources, FIFO status flags for the GPIF master, write forwarding.
module slave_fifo_scheduler
    import slave_fifo_scheduler_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              PCLK,
    input  logic              RESET,
    input  logic              RUN,
    input  logic              RD,
    input  logic              WR,
    input  logic              OE,
    inout  wire  [DATA_W-1:0] DQ,
    output logic              RD_FIFO_Empty,
    output logic              WR_FIFO_Full,
    output logic              LastRDData,
    input  logic [1:0]        SrcReq,
    input  logic [DATA_W-1:0] SrcData0,
    input  logic [DATA_W-1:0] SrcData1,
    output logic [1:0]        SrcAck,
    output logic [DATA_W-1:0] SinkData,
    output logic              SinkWr,
    input  logic              SinkFull,
    output logic [1:0]        Grant,
    output logic              Underrun,
    output logic [2:0]        State
);

    state_t            state_q;
    logic [CNT_W-1:0]  burst_cnt;
    logic [1:0]        grant_q;
    logic [1:0]        arb_gnt;
    logic              underrun_q;
    logic              granted_req;
    logic              pop;
    logic              last_word;
    logic              rr_done;
    logic [DATA_W-1:0] read_word;

    assign granted_req   = |(SrcReq & grant_q);
    assign last_word     = (burst_cnt == CNT_W'(1));
    // A pop is suppressed on the reset cycle so the discarded burst loses no data.
    assign pop           = (state_q == S_READ) && RD && granted_req && !RESET;
    assign SrcAck        = pop ? grant_q : 2'b00;

    assign RD_FIFO_Empty = !((state_q == S_READ) && granted_req);
    assign LastRDData    = (state_q == S_IDLE) || (state_q == S_STOP) ||
                           ((state_q == S_READ) && last_word);
    assign WR_FIFO_Full  = (state_q == S_IDLE) || SinkFull;

    assign SinkWr   = WR && !WR_FIFO_Full && !RD;
    assign SinkData = DQ;

    assign read_word = grant_q[1] ? SrcData1 :
                       grant_q[0] ? SrcData0 : {DATA_W{1'b0}};
    assign DQ        = OE ? read_word : {DATA_W{1'bz}};

    // Leaving READ for ARB either ends the burst or forfeits it; both rotate.
    assign rr_done = (state_q == S_READ) && RUN &&
                     ((pop && last_word) || !granted_req);

    assign Grant    = grant_q;
    assign Underrun = underrun_q;
    assign State    = state_q;

    rr_arbiter2 u_arb (
        .clk      (PCLK),
        .reset    (RESET),
        .req      (SrcReq),
        .done     (rr_done),
        .done_gnt (grant_q),
        .gnt      (arb_gnt)
    );

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            burst_cnt  <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (RD && RD_FIFO_Empty) underrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (RUN) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (!RUN) begin
                        state_q <= S_IDLE;
                    end else if (|arb_gnt) begin
                        grant_q   <= arb_gnt;
                        burst_cnt <= CNT_W'(BURST_LEN);
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    if (pop && burst_cnt != '0) burst_cnt <= burst_cnt - CNT_W'(1);
                    if (!RUN) begin
                        state_q <= S_STOP;
                    end else if (rr_done) begin
                        state_q <= S_ARB;
                        grant_q <= 2'b00;
                    end
                end
                S_STOP: begin
                    if (!RD) begin
                        state_q <= S_IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_fifo_scheduler.sv
// Bench for slave_fifo_scheduler with BURST_LEN=4: scoreboarded burst order,
// table-driven write path, and hand sequences for reset/underrun/stop corners.
module tb_slave_fifo_scheduler;

    logic        clk = 1'b0;
    logic        RESET, RUN, RD, WR, OE, SinkFull;
    logic [1:0]  SrcReq;
    logic [31:0] SrcData0, SrcData1, tb_dq, SinkData;
    wire  [31:0] DQ;
    logic        RD_FIFO_Empty, WR_FIFO_Full, LastRDData, SinkWr, Underrun;
    logic [1:0]  SrcAck, Grant;
    logic [2:0]  State;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int idx0   = 0;
    int idx1   = 0;
    int ack0_total = 0;
    bit sb_en  = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  ack;
        logic [31:0] data;
        logic        last;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        wr, rd, full;
        logic [31:0] dq;
        logic        exp_wr, exp_full;
    } wvec_t;
    wvec_t wvec[5];

    always #5 clk = ~clk;

    assign DQ       = OE ? 32'bz : tb_dq;
    assign SrcData0 = 32'hA000_0000 + 32'(idx0);
    assign SrcData1 = 32'hB000_0000 + 32'(idx1);

    slave_fifo_scheduler #(.BURST_LEN(4)) dut (
        .PCLK(clk), .RESET(RESET), .RUN(RUN), .RD(RD), .WR(WR), .OE(OE), .DQ(DQ),
        .RD_FIFO_Empty(RD_FIFO_Empty), .WR_FIFO_Full(WR_FIFO_Full),
        .LastRDData(LastRDData), .SrcReq(SrcReq), .SrcData0(SrcData0),
        .SrcData1(SrcData1), .SrcAck(SrcAck), .SinkData(SinkData),
        .SinkWr(SinkWr), .SinkFull(SinkFull), .Grant(Grant),
        .Underrun(Underrun), .State(State)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample point: negedge. Scoreboard compare, then the source models pop.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc_n++;
        if (sb_en && SrcAck != 2'b00) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", {30'd0, SrcAck}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_cycle", 32'(cyc_n), 32'(e.cyc));
                chk("sb_ack", {30'd0, SrcAck}, {30'd0, e.ack});
                chk("sb_dq", DQ, e.data);
                chk("sb_last", {31'd0, LastRDData}, {31'd0, e.last});
            end
        end
        if (SrcAck[0]) begin idx0++; ack0_total++; end
        if (SrcAck[1]) idx1++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        tick();
        adv();
    endtask

    task automatic do_reset();
        RESET = 1; RUN = 0; RD = 0; WR = 0; OE = 0; SinkFull = 0;
        SrcReq = 2'b00; tb_dq = 32'd0;
        cyc(); cyc();
        RESET = 0;
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int got = 0;
        for (int i = 0; i < budget && got < n; i++) begin
            tick();
            if (SrcAck != 2'b00) got++;
            adv();
        end
        if (got != n) chk(name, 32'(got), 32'(n));
    endtask

    initial begin
        int base;
        int b0, b1;
        bit found;

        wvec[0] = '{1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
        wvec[1] = '{1'b1, 1'b0, 1'b1, 32'hA5A5_0002, 1'b0, 1'b1};
        wvec[2] = '{1'b1, 1'b1, 1'b0, 32'hA5A5_0003, 1'b0, 1'b0};
        wvec[3] = '{1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
        wvec[4] = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};

        // Reset state
        do_reset();
        tick();
        chk("rst_state", {29'd0, State}, 32'd0);
        chk("rst_grant", {30'd0, Grant}, 32'd0);
        chk("rst_ack", {30'd0, SrcAck}, 32'd0);
        chk("rst_underrun", {31'd0, Underrun}, 32'd0);
        chk("rst_empty", {31'd0, RD_FIFO_Empty}, 32'd1);
        chk("rst_full", {31'd0, WR_FIFO_Full}, 32'd1);
        chk("rst_last", {31'd0, LastRDData}, 32'd1);
        adv();

        // Round-robin bursts of 4 with one ARB gap between grants
        do_reset();
        RUN = 1; SrcReq = 2'b11; RD = 1; OE = 1;
        base = cyc_n + 1;
        b0 = idx0; b1 = idx1;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{base + 2 + k,  2'b01, 32'hA000_0000 + 32'(b0 + k),     k == 3});
        end
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{base + 7 + k,  2'b10, 32'hB000_0000 + 32'(b1 + k),     k == 3});
        end
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{base + 12 + k, 2'b01, 32'hA000_0000 + 32'(b0 + 4 + k), k == 3});
        end
        sb_en = 1;
        repeat (17) cyc();
        sb_en = 0;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("rr_gap_underrun", {31'd0, Underrun}, 32'd1);

        // Reset mid-burst after 5 words; pointer returns to source 0
        do_reset();
        RUN = 1; SrcReq = 2'b11; RD = 1; OE = 1;
        wait_acks(5, 40, "t1_acks_timeout");
        RESET = 1;
        tick();
        chk("t1_no_ack_on_reset", {30'd0, SrcAck}, 32'd0);
        adv();
        tick();
        chk("t1_state", {29'd0, State}, 32'd0);
        chk("t1_grant", {30'd0, Grant}, 32'd0);
        chk("t1_empty", {31'd0, RD_FIFO_Empty}, 32'd1);
        chk("t1_full", {31'd0, WR_FIFO_Full}, 32'd1);
        RESET = 0; RD = 0;
        adv();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (State == 3'd2) found = 1;
            else adv();
        end
        chk("t1_reach_read", {31'd0, found}, 32'd1);
        chk("t1_regrant_src0", {30'd0, Grant}, 32'd1);
        adv();

        // Single requester drops mid-burst
        do_reset();
        ack0_total = 0;
        RUN = 1; SrcReq = 2'b10; RD = 1; OE = 1;
        wait_acks(2, 20, "t3_acks_timeout");
        SrcReq = 2'b00; RD = 0;
        tick();
        chk("t3_empty_on_drop", {31'd0, RD_FIFO_Empty}, 32'd1);
        adv();
        tick();
        chk("t3_state_arb", {29'd0, State}, 32'd1);
        chk("t3_grant", {30'd0, Grant}, 32'd0);
        chk("t3_empty", {31'd0, RD_FIFO_Empty}, 32'd1);
        chk("t3_src0_acks", 32'(ack0_total), 32'd0);
        adv();

        // Underrun: RD while empty in ARB, sticky until reset
        do_reset();
        RUN = 1;
        cyc(); cyc();
        tick();
        chk("t4_state_arb", {29'd0, State}, 32'd1);
        chk("t4_underrun_pre", {31'd0, Underrun}, 32'd0);
        adv();
        RD = 1;
        tick();
        chk("t4_no_ack", {30'd0, SrcAck}, 32'd0);
        adv();
        RD = 0;
        tick();
        chk("t4_underrun_set", {31'd0, Underrun}, 32'd1);
        adv();
        repeat (3) cyc();
        tick();
        chk("t4_underrun_held", {31'd0, Underrun}, 32'd1);
        adv();
        RESET = 1;
        cyc();
        RESET = 0;
        tick();
        chk("t4_underrun_cleared", {31'd0, Underrun}, 32'd0);
        adv();

        // Write path: IDLE blocks writes, then table in ARB
        do_reset();
        WR = 1; tb_dq = 32'hA5A5_0001;
        tick();
        chk("t5_idle_full", {31'd0, WR_FIFO_Full}, 32'd1);
        chk("t5_idle_sinkwr", {31'd0, SinkWr}, 32'd0);
        adv();
        WR = 0; RUN = 1;
        cyc(); cyc();
        for (int i = 0; i < 5; i++) begin
            WR = wvec[i].wr; RD = wvec[i].rd; SinkFull = wvec[i].full; tb_dq = wvec[i].dq;
            tick();
            chk($sformatf("t5_sinkwr[%0d]", i), {31'd0, SinkWr}, {31'd0, wvec[i].exp_wr});
            chk($sformatf("t5_full[%0d]", i), {31'd0, WR_FIFO_Full}, {31'd0, wvec[i].exp_full});
            chk($sformatf("t5_sinkdata[%0d]", i), SinkData, wvec[i].dq);
            adv();
        end
        WR = 0; RD = 0; SinkFull = 0;

        // RUN dropped mid-burst with RD high -> STOP, then IDLE once RD falls
        do_reset();
        RUN = 1; SrcReq = 2'b11; RD = 1; OE = 1;
        wait_acks(2, 20, "t6_acks_timeout");
        RUN = 0;
        cyc();
        tick();
        chk("t6_state_stop", {29'd0, State}, 32'd3);
        chk("t6_last", {31'd0, LastRDData}, 32'd1);
        chk("t6_empty", {31'd0, RD_FIFO_Empty}, 32'd1);
        chk("t6_no_ack", {30'd0, SrcAck}, 32'd0);
        adv();
        tick();
        chk("t6_still_stop", {29'd0, State}, 32'd3);
        chk("t6_no_ack2", {30'd0, SrcAck}, 32'd0);
        adv();
        RD = 0;
        cyc();
        tick();
        chk("t6_state_idle", {29'd0, State}, 32'd0);
        chk("t6_grant_clr", {30'd0, Grant}, 32'd0);
        adv();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
